param_priority_arbiter: RTL and testbench

PARAM_PRIORITY_ARBITER -- requirements
Module: param_priority_arbiter

---
 rtl/param_priority_arbiter.sv | 114 +++++++++++
 tb/tb_param_priority_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/param_priority_arbiter.sv
// Priority / round-robin arbiter with optional per-owner hold limit.
// The grant is registered; an owner keeps it until it drops its request or exhausts MAX_HOLD.
module param_priority_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic             arb_clk,
  input  logic             arb_rst_n,
  input  logic             arb_mode,
  input  logic [N_REQ-1:0] arb_req,
  output logic [N_REQ-1:0] arb_gnt,
  output logic [IDW-1:0]   arb_gnt_id,
  output logic             arb_gnt_vld,
  output logic             arb_preempt
);

  // state | meaning
  // IDLE  | no owner, grant lines low
  // OWN   | one requester owns the grant (index in arb_gnt_id)
  typedef enum logic {IDLE, OWN} state_t;

  localparam int             HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, ptr_nxt, id_nxt, win;
  logic [HCW-1:0]   hold_cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt, elig, others;
  logic             pre_nxt, do_arb;

  // First set bit of elig, scanning upward from ptr (round-robin) or from 0 (fixed).
  function automatic logic [IDW-1:0] pick(input logic [N_REQ-1:0] vec,
                                          input logic rr, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] sel, idx;
    logic           found;
    sel   = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = rr ? IDW'((int'(ptr) + j) % N_REQ) : IDW'(j);
      if (!found && vec[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_nxt = state;
    id_nxt    = arb_gnt_id;
    cnt_nxt   = hold_cnt;
    ptr_nxt   = rr_ptr;
    pre_nxt   = 1'b0;
    do_arb    = 1'b0;
    elig      = arb_req;
    others    = arb_req & ~arb_gnt;
    win       = '0;
    gnt_nxt   = '0;

    case (state)
      IDLE: do_arb = |arb_req;
      OWN: begin
        if (!arb_req[arb_gnt_id]) begin
          if (|arb_req) do_arb = 1'b1;
          else          state_nxt = IDLE;
        end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
          if (|others) begin
            elig    = others;
            do_arb  = 1'b1;
            pre_nxt = 1'b1;
          end else begin
            cnt_nxt = '0;  // sole requester: re-grant in place
          end
        end else if (HOLD_EN) begin
          cnt_nxt = hold_cnt + HCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_arb) begin
      win       = pick(elig, arb_mode, rr_ptr);
      state_nxt = OWN;
      id_nxt    = win;
      cnt_nxt   = '0;
      ptr_nxt   = IDW'((int'(win) + 1) % N_REQ);
    end

    if (state_nxt == OWN) gnt_nxt[id_nxt] = 1'b1;
  end

  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state       <= IDLE;
      arb_gnt     <= '0;
      arb_gnt_id  <= '0;
      arb_gnt_vld <= 1'b0;
      arb_preempt <= 1'b0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      arb_gnt     <= gnt_nxt;
      arb_gnt_id  <= id_nxt;
      arb_gnt_vld <= (state_nxt == OWN);
      arb_preempt <= pre_nxt;
      rr_ptr      <= ptr_nxt;
      hold_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Bench: two arbiters (unlimited hold, MAX_HOLD=4) on shared stimulus, checked
// against a cycle-level reference of the arbitration rules.
module tb_param_priority_arbiter;

  logic       arb_clk = 1'b0;
  logic       arb_rst_n;
  logic       arb_mode;
  logic [3:0] arb_req;
  logic [3:0] gnt [2];
  logic [1:0] gid [2];
  logic       vld [2];
  logic       pre [2];

  int checks = 0;
  int errors = 0;

  int mh    [2] = '{0, 4};
  int m_own [2];
  int m_id  [2];
  int m_rr  [2];
  int m_cnt [2];
  int m_pre [2];

  always #5 arb_clk = ~arb_clk;

  param_priority_arbiter #(.N_REQ(4), .MAX_HOLD(0)) u_a (
    .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .arb_mode(arb_mode), .arb_req(arb_req),
    .arb_gnt(gnt[0]), .arb_gnt_id(gid[0]), .arb_gnt_vld(vld[0]), .arb_preempt(pre[0]));

  param_priority_arbiter #(.N_REQ(4), .MAX_HOLD(4)) u_b (
    .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .arb_mode(arb_mode), .arb_req(arb_req),
    .arb_gnt(gnt[1]), .arb_gnt_id(gid[1]), .arb_gnt_vld(vld[1]), .arb_preempt(pre[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int vec, input int rr_mode, input int ptr);
    int idx;
    for (int j = 0; j < 4; j++) begin
      idx = rr_mode ? (ptr + j) % 4 : j;
      if ((vec >> idx) & 1) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_id[k] = 0; m_rr[k] = 0; m_cnt[k] = 0; m_pre[k] = 0;
    end
  endtask

  task automatic model_grant(input int k, input int w);
    m_own[k] = 1;
    m_id[k]  = w;
    m_cnt[k] = 0;
    m_rr[k]  = (w + 1) % 4;
  endtask

  task automatic model_step();
    int r, others;
    r = int'(arb_req);
    for (int k = 0; k < 2; k++) begin
      m_pre[k] = 0;
      if (m_own[k] == 0) begin
        if (r != 0) model_grant(k, pick(r, int'(arb_mode), m_rr[k]));
      end else if (((r >> m_id[k]) & 1) == 0) begin
        if (r != 0) model_grant(k, pick(r, int'(arb_mode), m_rr[k]));
        else m_own[k] = 0;
      end else if (mh[k] != 0 && m_cnt[k] == mh[k] - 1) begin
        others = r & ~(1 << m_id[k]);
        if (others != 0) begin
          model_grant(k, pick(others, int'(arb_mode), m_rr[k]));
          m_pre[k] = 1;
        end else m_cnt[k] = 0;
      end else if (mh[k] != 0) begin
        m_cnt[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt%0d", k), 32'(gnt[k]), m_own[k] != 0 ? 32'(1 << m_id[k]) : 32'd0);
      chk($sformatf("vld%0d", k), 32'(vld[k]), 32'(m_own[k] != 0));
      chk($sformatf("pre%0d", k), 32'(pre[k]), 32'(m_pre[k]));
      if (m_own[k] != 0) chk($sformatf("id%0d", k), 32'(gid[k]), 32'(m_id[k]));
    end
  endtask

  task automatic cycle();
    @(posedge arb_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_gnt"}, 32'(gnt[k]), 32'd0);
      chk({tag, "_id"},  32'(gid[k]), 32'd0);
      chk({tag, "_vld"}, 32'(vld[k]), 32'd0);
      chk({tag, "_pre"}, 32'(pre[k]), 32'd0);
    end
  endtask

  initial begin
    arb_rst_n = 1'b0;
    arb_mode  = 1'b0;
    arb_req   = 4'b0000;
    model_reset();
    #12;
    check_zero("rst");
    @(negedge arb_clk);
    arb_rst_n = 1'b1;

    // fixed priority, release hands over with no idle cycle
    arb_req = 4'b1010;
    cycle();
    chk("s31_first", 32'(gnt[0]), 32'b0010);
    arb_req = 4'b1000;
    cycle();
    chk("s31_handover", 32'(gnt[0]), 32'b1000);

    // hold limit alternates two requesters
    arb_req = 4'b0000;
    cycle();
    arb_req = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      chk("s33_gnt", 32'(gnt[1]), (((c - 1) / 4) % 2) != 0 ? 32'b0010 : 32'b0001);
      chk("s33_pre", 32'(pre[1]), 32'(c > 1 && (c - 1) % 4 == 0));
      chk("s33_nolimit", 32'(gnt[0]), 32'b0001);
    end

    // sole requester at the limit is re-granted without preempt
    arb_req = 4'b0100;
    cycle();
    for (int c = 0; c < 12; c++) begin
      cycle();
      chk("s34_gnt", 32'(gnt[1]), 32'b0100);
      chk("s34_pre", 32'(pre[1]), 32'd0);
    end

    // mode change while holding does not disturb the owner
    arb_req = 4'b0000;
    cycle();
    arb_req = 4'b1000;
    cycle();
    arb_req  = 4'b1001;
    arb_mode = 1'b1;
    cycle();
    chk("s35_hold_a", 32'(gnt[0]), 32'b1000);
    cycle();
    arb_mode = 1'b0;
    cycle();
    chk("s35_hold_b", 32'(gnt[0]), 32'b1000);
    arb_mode = 1'b1;
    arb_req  = 4'b0011;
    cycle();
    chk("s35_release", 32'(gnt[0]), 32'b0001);
    cycle();

    // asynchronous reset mid-grant, then round-robin restarts from 0
    #3;
    arb_rst_n = 1'b0;
    #1;
    check_zero("s36_async");
    model_reset();
    @(negedge arb_clk);
    arb_req   = 4'b1000;
    arb_mode  = 1'b1;
    arb_rst_n = 1'b1;
    cycle();
    chk("s36_gnt", 32'(gnt[0]), 32'b1000);
    chk("s36_id",  32'(gid[0]), 32'd3);

    // round-robin rotation, each owner drops for one cycle after two grant cycles
    arb_req = 4'b0000;
    cycle();
    arb_req = 4'b1111;
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("s32_order", 32'(gid[0]), 32'(k % 4));
      chk("s32_gnt", 32'(gnt[0]), 32'(1 << (k % 4)));
      cycle();
      arb_req = 4'b1111 & ~(4'b0001 << m_id[0]);
      cycle();
      arb_req = 4'b1111;
    end

    // randomized traffic against the reference
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) arb_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) arb_mode = ~arb_mode;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
